cdc_handshake_tx: RTL and testbench
===================================

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter DATA_W, default 8, width of the transferred word.
REQ-002 Parameter SYNC_STAGES, default 3, number of flops in the ack synchronizer; legal range 2..4.
REQ-003 Parameter TIMEOUT_CYCLES, default 1023, max cycles spent waiting for ack high; used only when CDC_TX_TIMEOUT_EN is defined.
REQ-004 clk  input  1  sole clock, all flops rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_data  input  DATA_W  word to transfer into the destination domain.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  block accepts a word this cycle.
REQ-009 tx_data  output  DATA_W  registered word presented to the destination domain.
REQ-010 tx_req  output  1  registered 4-phase request to the destination domain.
REQ-011 rx_ack  input  1  4-phase acknowledge from the destination domain, asynchronous to clk.
REQ-012 busy  output  1  transfer in progress (state != IDLE).
REQ-013 done  output  1  one-cycle pulse, transfer completed.
REQ-014 err  output  1  one-cycle pulse, ack timeout; tied 0 without CDC_TX_TIMEOUT_EN.

Function
REQ-015 rx_ack SHALL pass through a SYNC_STAGES-deep flop chain marked ASYNC_REG before any use; ack_s denotes the last stage; no other logic reads rx_ack.
REQ-016 FSM SHALL have states IDLE, REQ_HI (tx_req=1, waiting ack_s=1), REQ_LO (tx_req=0, waiting ack_s=0).
REQ-017 s_ready SHALL equal (state==IDLE && ack_s==0), combinational from registers only.
REQ-018 On s_valid && s_ready at an edge: tx_data <= s_data, tx_req <= 1, state <= REQ_HI, all on that same edge.
REQ-019 tx_data SHALL change only on acceptance (REQ-018) or reset; held stable through REQ_HI and REQ_LO.
REQ-020 In REQ_HI with ack_s==1: tx_req <= 0, state <= REQ_LO.
REQ-021 In REQ_LO with ack_s==0: state <= IDLE, done <= 1 for exactly that one following cycle.
REQ-022 s_valid in non-IDLE states SHALL be ignored; no word is dropped silently since s_ready=0.
REQ-023 Stale ack_s=1 in IDLE (destination slow to release) SHALL hold s_ready=0 until ack_s returns 0.
REQ-024 Minimum transfer: ack seen after SYNC_STAGES cycles each edge; with instantaneous destination, acceptance-to-done = 2*SYNC_STAGES+2 cycles ±1 for destination sync.
REQ-025 tx_req SHALL be driven directly from a flop, no combinational path to the port.

Reset
REQ-026 rst high SHALL immediately force state=IDLE, tx_req=0, tx_data=0, done=0, err=0, all synchronizer flops=0, timeout counter=0.
REQ-027 Reset mid-transfer SHALL abandon the word; after release s_ready rises only once ack_s==0 (REQ-017).

Configuration
REQ-028 Macro CDC_TX_TIMEOUT_EN defined: counter clears on entry to REQ_HI, increments each REQ_HI cycle; on reaching TIMEOUT_CYCLES with ack_s still 0, tx_req <= 0, state <= REQ_LO, err pulses 1 cycle, done not asserted for that word.
REQ-029 Macro CDC_TX_TIMEOUT_EN undefined: no counter logic, err tied 0, REQ_HI waits indefinitely.

Verification
REQ-030 Single transfer: SYNC_STAGES=3, s_data=0xA5, destination acks 2 cycles after tx_req, releases 2 cycles after tx_req falls -> tx_data=0xA5 stable throughout, one done pulse, s_ready back to 1 next cycle.
REQ-031 Back-to-back: s_valid held with 0x01,0x02,0x03 -> three handshakes, tx_data sequence 0x01,0x02,0x03, three done pulses, no word duplicated or skipped.
REQ-032 Stale ack: rx_ack=1 during IDLE for 10 cycles with s_valid=1 -> s_ready=0, tx_req=0 until 3 cycles after rx_ack falls, then acceptance.
REQ-033 Reset mid-transfer: rst pulsed while in REQ_HI -> tx_req=0 and tx_data=0 in the same cycle as rst, no done, clean transfer of 0x3C afterwards.
REQ-034 Timeout (macro defined, TIMEOUT_CYCLES=16): rx_ack held 0 -> tx_req falls and err pulses exactly once, 16 cycles after entry to REQ_HI, no done, s_ready returns to 1.
REQ-035 Macro undefined, rx_ack held 0 for 5000 cycles -> tx_req stays 1, err stays 0.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - 4-phase req/ack CDC transmitter with synchronized ack.
// Optional ack-timeout abort is compiled in with CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
   parameter int DATA_W         = 8,
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_req,
   input  logic              rx_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

   state_t                 state_q, state_d;
   (* ASYNC_REG = "TRUE" *)
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic [SYNC_STAGES-1:0] ack_sync_d;
   logic [DATA_W-1:0]      tx_data_q, tx_data_d;
   logic                   tx_req_q, tx_req_d;
   logic                   done_q, done_d;
   logic                   ack_s;
   logic                   accept;
   logic                   timeout;
   logic                   timed_out;

   assign ack_s   = ack_sync_q[SYNC_STAGES-1];
   assign s_ready = (state_q == IDLE) && !ack_s;
   assign accept  = s_valid && s_ready;
   assign busy    = (state_q != IDLE);
   assign tx_data = tx_data_q;
   assign tx_req  = tx_req_q;
   assign done    = done_q;

`ifdef CDC_TX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
   logic             err_q, err_d;

   assign timeout   = (state_q == REQ_HI) && !ack_s && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timed_out = to_q;
   assign err       = err_q;

   // to_q remembers an aborted word so its REQ_LO exit does not report done.
   always_comb begin
      cnt_d = cnt_q;
      to_d  = to_q;
      err_d = timeout;
      if (accept) begin
         cnt_d = '0;
         to_d  = 1'b0;
      end else if (state_q == REQ_HI) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (timeout) to_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
         err_q <= err_d;
      end
   end
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign timeout        = 1'b0;
   assign timed_out      = 1'b0;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ack_sync_q <= '0;
         tx_data_q  <= '0;
         tx_req_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_sync_q <= ack_sync_d;
         tx_data_q  <= tx_data_d;
         tx_req_q   <= tx_req_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = REQ_HI;
         REQ_HI:  if (ack_s || timeout) state_d = REQ_LO;
         REQ_LO:  if (!ack_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], rx_ack};
      tx_data_d  = tx_data_q;
      tx_req_d   = tx_req_q;
      done_d     = 1'b0;
      if (accept) begin
         tx_data_d = s_data;
         tx_req_d  = 1'b1;
      end
      if ((state_q == REQ_HI) && (ack_s || timeout)) tx_req_d = 1'b0;
      if ((state_q == REQ_LO) && !ack_s) done_d = !timed_out;
   end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - randomized bench with cycle-level reference model.
// Builds with or without CDC_TX_TIMEOUT_EN.
module tb_cdc_handshake_tx;
   localparam int S    = 3;
   localparam int T    = 16;
   localparam int LAT0 = 2 * S + 3;
   localparam int BIG  = 1 << 30;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       rx_ack = 1'b0;
   logic       busy, done, err;

   always #5 clk = ~clk;

   cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .tx_data(tx_data), .tx_req(tx_req), .rx_ack(rx_ack),
      .busy(busy), .done(done), .err(err)
   );

   int n_vec = 0, n_bad = 0, cyc = 0;
   bit auto_mode = 1'b1, man_ack = 1'b0;
   int d_hi = 0, d_lo = 0, wcnt = 0, nd1 = 0, nd2 = 0;
   bit has_acc = 1'b0;
   int acc_cyc = 0, exp_done = -1, exp_err = -1, exp_idle = 0, exp_fall = 0;
   logic [7:0] last_word = 8'h00;
   bit hist[$];
   logic [7:0] acc_log[$];
   int ndone = 0, done_cyc = 0, nerr = 0, err_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // hist[0] is rx_ack as driven S cycles ago, i.e. what the synchronizer now shows.
   task automatic monitor();
      bit in_fl;
      in_fl = has_acc && (cyc > acc_cyc) && (cyc < exp_idle);
      check_eq("s_ready", 32'(s_ready), 32'(!in_fl && !hist[0]));
      check_eq("busy",    32'(busy),    32'(in_fl));
      check_eq("tx_req",  32'(tx_req),  32'(in_fl && (cyc < exp_fall)));
      check_eq("done",    32'(done),    32'(has_acc && (cyc == exp_done)));
      check_eq("err",     32'(err),     32'(has_acc && (cyc == exp_err)));
      check_eq("tx_data", 32'(tx_data), 32'(last_word));
      if (done === 1'b1) begin ndone++; done_cyc = cyc; end
      if (err === 1'b1) begin nerr++; err_cyc = cyc; end
   endtask

   task automatic responder();
      if (!auto_mode) rx_ack = man_ack;
      else if (tx_req !== rx_ack) begin
         if (wcnt >= (tx_req ? d_hi : d_lo)) begin
            rx_ack = tx_req;
            wcnt   = 0;
         end else wcnt++;
      end
   endtask

   task automatic accept(input logic [7:0] d);
      has_acc = 1'b1; acc_cyc = cyc; last_word = d; acc_log.push_back(d);
      d_hi = nd1; d_lo = nd2; wcnt = 0; exp_done = -1;
      if (auto_mode) begin
         exp_done = cyc + LAT0 + nd1 + nd2;
         exp_idle = exp_done;
         exp_fall = cyc + nd1 + S + 2;
         exp_err  = -1;
      end else begin
`ifdef CDC_TX_TIMEOUT_EN
         exp_err  = cyc + T + 1;
         exp_fall = exp_err;
         exp_idle = cyc + T + 2;
`else
         exp_err  = -1;
         exp_fall = BIG;
         exp_idle = BIG;
`endif
      end
   endtask

   task automatic cycle(input bit v, input logic [7:0] d);
      @(negedge clk);
      cyc++;
      monitor();
      responder();
      hist.push_back(rx_ack);
      hist.delete(0);
      s_valid = v;
      s_data  = d;
      if (v && s_ready === 1'b1) accept(d);
   endtask

   task automatic wait_done(input string tag);
      int n0 = ndone;
      int k  = 0;
      while (ndone == n0 && k < 200) begin cycle(1'b0, 8'h00); k++; end
      check_eq(tag, 32'(ndone - n0), 32'd1);
   endtask

   task automatic reset_mid();
      #2 rst = 1'b1;
      #1;
      check_eq("rst_req",  32'(tx_req),  32'd0);
      check_eq("rst_data", 32'(tx_data), 32'd0);
      check_eq("rst_busy", 32'(busy),    32'd0);
      check_eq("rst_done", 32'(done),    32'd0);
      s_valid = 1'b0; rx_ack = 1'b0; man_ack = 1'b0; wcnt = 0;
      has_acc = 1'b0; last_word = 8'h00;
      for (int i = 0; i < S; i++) hist[i] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int a, n0, e0, k, sz, sz0, idx, drop;
      for (int i = 0; i < S; i++) hist.push_back(1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 8'h00);

      nd1 = 2; nd2 = 2;
      cycle(1'b1, 8'hA5);
      a = acc_cyc;
      wait_done("a5_done");
      check_eq("a5_lat", 32'(done_cyc - a), 32'(LAT0 + 4));
      cycle(1'b0, 8'h00);
      cycle(1'b0, 8'h00);

      acc_log.delete(); nd1 = 0; nd2 = 0; idx = 0; n0 = ndone; k = 0;
      while ((ndone - n0) < 3 && k < 200) begin
         sz = acc_log.size();
         cycle(idx < 3, (idx < 3) ? 8'(idx + 1) : 8'h00);
         if (acc_log.size() > sz) idx++;
         k++;
      end
      check_eq("b2b_dones", 32'(ndone - n0), 32'd3);
      check_eq("b2b_cnt", 32'(acc_log.size()), 32'd3);
      for (int i = 0; i < acc_log.size() && i < 3; i++)
         check_eq("b2b_word", 32'(acc_log[i]), 32'(i + 1));

      auto_mode = 1'b0; man_ack = 1'b1;
      for (int i = 0; i < 10; i++) cycle(i >= S, 8'hC3);
      auto_mode = 1'b1; d_lo = 0; wcnt = 0; nd1 = 1; nd2 = 1;
      sz = acc_log.size();
      cycle(1'b1, 8'hC3);
      drop = cyc; k = 0;
      while (acc_log.size() == sz && k < 20) begin cycle(1'b1, 8'hC3); k++; end
      check_eq("stale_lat", 32'(acc_cyc - drop), 32'(S));
      wait_done("stale_done");

      nd1 = 8; nd2 = 0;
      cycle(1'b1, 8'h77);
      repeat (3) cycle(1'b0, 8'h00);
      check_eq("pre_rst_req", 32'(tx_req), 32'd1);
      reset_mid();
      n0 = ndone;
      repeat (4) cycle(1'b0, 8'h00);
      check_eq("rst_nodone", 32'(ndone - n0), 32'd0);
      nd1 = 1; nd2 = 1;
      cycle(1'b1, 8'h3C);
      wait_done("3c_done");
      check_eq("3c_data", 32'(tx_data), 32'h3C);

      n0 = ndone; sz0 = acc_log.size(); k = 0;
      while ((acc_log.size() - sz0) < 40 && k < 4000) begin
         nd1 = $urandom_range(0, 4);
         nd2 = $urandom_range(0, 4);
         cycle($urandom_range(0, 3) != 0, 8'($urandom));
         k++;
      end
      repeat (30) cycle(1'b0, 8'h00);
      check_eq("rand_cnt", 32'(acc_log.size() - sz0), 32'd40);
      check_eq("rand_dones", 32'(ndone - n0), 32'(acc_log.size() - sz0));

`ifdef CDC_TX_TIMEOUT_EN
      auto_mode = 1'b0; man_ack = 1'b0; n0 = ndone; e0 = nerr;
      cycle(1'b1, 8'h5A);
      a = acc_cyc; k = 0;
      while (nerr == e0 && k < 40) begin cycle(1'b0, 8'h00); k++; end
      check_eq("to_lat", 32'(err_cyc - a), 32'(T + 1));
      repeat (5) cycle(1'b0, 8'h00);
      check_eq("to_errs", 32'(nerr - e0), 32'd1);
      check_eq("to_nodone", 32'(ndone - n0), 32'd0);
      check_eq("to_ready", 32'(s_ready), 32'd1);
      auto_mode = 1'b1;
`else
      auto_mode = 1'b0; man_ack = 1'b0; e0 = nerr;
      cycle(1'b1, 8'h5A);
      repeat (5000) cycle(1'b0, 8'h00);
      check_eq("hang_req", 32'(tx_req), 32'd1);
      check_eq("hang_errs", 32'(nerr - e0), 32'd0);
      reset_mid();
      auto_mode = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
